// File: rtl/writeback_stage.sv
// Writeback stage: load alignment, response wait/hold FSM, RF write port.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module writeback_stage #(
  parameter int INSTRET_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 valid_i,
  input  logic [63:0]          rd_data_i,
  input  logic [4:0]           rd_idx_i,
  input  logic                 rd_wr_en_i,
  input  logic [2:0]           rd_wr_src_1h_i,
  input  logic [3:0]           mem_width_1h_i,
  input  logic                 mem_sign_i,
  input  logic [2:0]           byte_addr_i,
  input  logic                 dmem_rvalid_i,
  input  logic [63:0]          dmem_rdata_i,
  output logic                 dmem_stall_ao,
  output logic                 rf_wr_en_o,
  output logic [4:0]           rf_wr_idx_o,
  output logic [63:0]          rf_wr_data_o,
  output logic                 retire_o
`ifdef WB_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret_o
`endif
);

  localparam logic [3:0] MEM_WIDTH_1H_BYTE   = 4'b0001;
  localparam logic [3:0] MEM_WIDTH_1H_HALF   = 4'b0010;
  localparam logic [3:0] MEM_WIDTH_1H_WORD   = 4'b0100;
  localparam logic [3:0] MEM_WIDTH_1H_DOUBLE = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HELD
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_capture;
  logic [63:0] r_rdata_q;
  logic        w_load;
  logic        w_held;
  logic [63:0] w_src;
  logic [63:0] w_line;
  logic [63:0] w_ext;
  logic        w_dstall;
  logic        w_retire;

  assign w_load = valid_i & rd_wr_src_1h_i[1];
  assign w_held = (r_state == ST_HELD);
  assign w_src  = w_held ? r_rdata_q : dmem_rdata_i;
  assign w_line = w_src >> {byte_addr_i, 3'b000};

  // Width select and sign/zero extension of the aligned load line
  always_comb begin
    w_ext = '0;
    case (mem_width_1h_i)
      MEM_WIDTH_1H_BYTE:
        w_ext = {{56{mem_sign_i & w_line[7]}}, w_line[7:0]};
      MEM_WIDTH_1H_HALF:
        w_ext = {{48{mem_sign_i & w_line[15]}}, w_line[15:0]};
      MEM_WIDTH_1H_WORD:
        w_ext = {{32{mem_sign_i & w_line[31]}}, w_line[31:0]};
      MEM_WIDTH_1H_DOUBLE:
        w_ext = w_src;
      default:
        w_ext = '0;
    endcase
  end

  assign w_dstall = ~rst_i & w_load & ~dmem_rvalid_i & ~w_held;
  assign w_retire = ~rst_i & valid_i & ~stall_i & ~w_dstall
                  & (~w_load | dmem_rvalid_i | w_held);

  assign dmem_stall_ao = w_dstall;
  assign retire_o      = w_retire;
  assign rf_wr_en_o    = w_retire & rd_wr_en_i & (rd_idx_i != 5'd0);
  assign rf_wr_idx_o   = rst_i ? 5'd0 : rd_idx_i;
  assign rf_wr_data_o  = rst_i ? 64'd0
                       : (rd_wr_src_1h_i[1] ? w_ext : rd_data_i);

  // Next state: wait for response, park it under stall, release on unstall
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          if (!dmem_rvalid_i) begin
            w_next = ST_WAIT;
          end else if (stall_i) begin
            w_next    = ST_HELD;
            w_capture = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (w_load & dmem_rvalid_i) begin
          if (stall_i) begin
            w_next    = ST_HELD;
            w_capture = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      ST_HELD: begin
        if (!stall_i) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register and held load-data buffer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_rdata_q <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_rdata_q <= dmem_rdata_i;
    end
  end

`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] r_instret;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
  end

  assign instret_o = r_instret;

  logic w_unused;
  assign w_unused = rd_wr_src_1h_i[2] ^ rd_wr_src_1h_i[0];
`else
  logic [INSTRET_W:0] w_unused;
  assign w_unused = {{INSTRET_W{1'b0}},
                     rd_wr_src_1h_i[2] ^ rd_wr_src_1h_i[0]};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Writeback stage bench: spec-level model plus directed literal vectors.
// Define WB_INSTRET_EN to also check the retired-instruction counter.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, valid, wen, sign, rvalid;
  logic [63:0] rd_data, rdata;
  logic [4:0]  idx;
  logic [2:0]  src, addr;
  logic [3:0]  width;
  logic        o_dstall, o_wen, o_ret;
  logic [4:0]  o_idx;
  logic [63:0] o_data;
`ifdef WB_INSTRET_EN
  logic [3:0]  o_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  writeback_stage #(.INSTRET_W(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .valid_i        (valid),
    .rd_data_i      (rd_data),
    .rd_idx_i       (idx),
    .rd_wr_en_i     (wen),
    .rd_wr_src_1h_i (src),
    .mem_width_1h_i (width),
    .mem_sign_i     (sign),
    .byte_addr_i    (addr),
    .dmem_rvalid_i  (rvalid),
    .dmem_rdata_i   (rdata),
    .dmem_stall_ao  (o_dstall),
    .rf_wr_en_o     (o_wen),
    .rf_wr_idx_o    (o_idx),
    .rf_wr_data_o   (o_data),
    .retire_o       (o_ret)
`ifdef WB_INSTRET_EN
    ,
    .instret_o      (o_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Load result from the rules: shift, pick width, extend numerically
  function automatic logic [63:0] f_ext(input logic [63:0] s,
                                        input logic [3:0] w,
                                        input logic sg,
                                        input logic [2:0] a);
    logic [63:0] sh;
    logic [63:0] v;
    sh = s >> (int'(a) * 8);
    case (w)
      4'b0001: begin
        v = 64'(sh[7:0]);
        if (sg && v >= 64'd128) v = v - 64'd256;
      end
      4'b0010: begin
        v = 64'(sh[15:0]);
        if (sg && v >= 64'd32768) v = v - 64'd65536;
      end
      4'b0100: begin
        v = 64'(sh[31:0]);
        if (sg && v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
      end
      4'b1000: v = s;
      default: v = 64'd0;
    endcase
    return v;
  endfunction

  // Model: whether a response is parked, and its data
  logic        m_held;
  logic [63:0] m_hdata;
  logic [3:0]  m_cnt;
  logic        e_load, e_dstall, e_ret, e_wen;
  logic [63:0] e_data;

  assign e_load   = valid & src[1];
  assign e_dstall = e_load & !rvalid & !m_held;
  assign e_ret    = valid & !stall & (!e_load | rvalid | m_held);
  assign e_wen    = e_ret & wen & (idx != 5'd0);
  assign e_data   = e_load
                  ? f_ext(m_held ? m_hdata : rdata, width, sign, addr)
                  : rd_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_held  <= 1'b0;
      m_hdata <= '0;
      m_cnt   <= '0;
    end else begin
      if (e_ret) m_cnt <= m_cnt + 4'd1;
      if (m_held && !stall) m_held <= 1'b0;
      if (e_load && !m_held && rvalid && stall) begin
        m_held  <= 1'b1;
        m_hdata <= rdata;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_dstall", 64'(o_dstall), 64'(e_dstall));
      chk("m_retire", 64'(o_ret), 64'(e_ret));
      chk("m_wen", 64'(o_wen), 64'(e_wen));
      chk("m_idx", 64'(o_idx), 64'(idx));
      if (e_ret) chk("m_data", o_data, e_data);
`ifdef WB_INSTRET_EN
      chk("m_instret", 64'(o_cnt), 64'(m_cnt));
`endif
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    valid  = 1'b0;
    stall  = 1'b0;
    rvalid = 1'b0;
    src    = 3'b001;
  endtask

  task automatic alu(input logic [63:0] d, input logic [4:0] i,
                     input logic we, input logic st);
    valid   = 1'b1;
    src     = 3'b001;
    rd_data = d;
    idx     = i;
    wen     = we;
    stall   = st;
    rvalid  = 1'b0;
    width   = 4'b0001;
  endtask

  task automatic ld(input logic [63:0] rd, input logic [3:0] w,
                    input logic sg, input logic [2:0] a,
                    input logic rv, input logic st);
    valid   = 1'b1;
    src     = 3'b010;
    idx     = 5'd7;
    wen     = 1'b1;
    rd_data = 64'hDEAD;
    width   = w;
    sign    = sg;
    addr    = a;
    rvalid  = rv;
    rdata   = rd;
    stall   = st;
  endtask

  initial begin
    rst = 1'b1;
    sign = 1'b0;
    addr = 3'd0;
    rdata = '0;
    alu(64'h1234, 5'd5, 1'b1, 1'b0);
    repeat (2) settle();
    chk("rst_retire", 64'(o_ret), 64'd0);
    chk("rst_wen", 64'(o_wen), 64'd0);
    chk("rst_idx", 64'(o_idx), 64'd0);
    chk("rst_data", o_data, 64'd0);
    chk("rst_dstall", 64'(o_dstall), 64'd0);

    nxt(); rst = 1'b0;
    alu(64'h1234, 5'd5, 1'b1, 1'b0);
    settle();
    chk("alu_wen", 64'(o_wen), 64'd1);
    chk("alu_idx", 64'(o_idx), 64'd5);
    chk("alu_data", o_data, 64'h1234);
    chk("alu_retire", 64'(o_ret), 64'd1);

    nxt(); ld(64'h0000_0000_8000_0000, 4'b0001, 1'b1, 3'd3, 1'b1, 1'b0);
    settle();
    chk("lb_data", o_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_retire", 64'(o_ret), 64'd1);
    nxt(); ld(64'h0000_0000_8000_0000, 4'b0001, 1'b0, 3'd3, 1'b1, 1'b0);
    settle();
    chk("lbu_data", o_data, 64'h80);

    for (int k = 0; k < 3; k++) begin
      nxt(); ld(64'h0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
      settle();
      chk("late_dstall", 64'(o_dstall), 64'd1);
      chk("late_retire", 64'(o_ret), 64'd0);
    end
    nxt(); ld(64'h1122_3344_5566_7788, 4'b1000, 1'b0, 3'd0, 1'b1, 1'b0);
    settle();
    chk("late_dstall_off", 64'(o_dstall), 64'd0);
    chk("late_data", o_data, 64'h1122_3344_5566_7788);
    chk("late_retire_on", 64'(o_ret), 64'd1);

    nxt(); ld(64'h8765_4321_0000_0000, 4'b0100, 1'b1, 3'd4, 1'b1, 1'b1);
    settle();
    chk("hold_retire0", 64'(o_ret), 64'd0);
    nxt(); ld(64'h0, 4'b0100, 1'b1, 3'd4, 1'b0, 1'b1);
    settle();
    chk("hold_dstall", 64'(o_dstall), 64'd0);
    chk("hold_retire1", 64'(o_ret), 64'd0);
    nxt(); ld(64'h5555_5555_5555_5555, 4'b0100, 1'b1, 3'd4, 1'b1, 1'b0);
    settle();
    chk("hold_retire", 64'(o_ret), 64'd1);
    chk("hold_data", o_data, 64'hFFFF_FFFF_8765_4321);

    nxt(); alu(64'h99, 5'd0, 1'b1, 1'b0);
    settle();
    chk("x0_wen", 64'(o_wen), 64'd0);
    chk("x0_retire", 64'(o_ret), 64'd1);

    nxt(); ld(64'hBEEF_0000_0000_0000, 4'b0010, 1'b1, 3'd6, 1'b1, 1'b0);
    settle();
    chk("lh_data", o_data, 64'hFFFF_FFFF_FFFF_BEEF);
    nxt(); ld(64'hFFFF_FFFF_FFFF_FFFF, 4'b0011, 1'b1, 3'd0, 1'b1, 1'b0);
    settle();
    chk("badw_data", o_data, 64'd0);

    nxt(); idle(); rvalid = 1'b1; rdata = 64'h77;
    settle();
    chk("norm_retire", 64'(o_ret), 64'd0);
    nxt(); alu(64'h42, 5'd3, 1'b1, 1'b1);
    settle();
    chk("stall_retire", 64'(o_ret), 64'd0);
    nxt(); alu(64'h42, 5'd3, 1'b1, 1'b0);
    settle();
    chk("after_norm_ret", 64'(o_ret), 64'd1);

    nxt(); ld(64'h0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
    settle();
    nxt(); ld(64'h0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_dstall", 64'(o_dstall), 64'd0);
    chk("arst_retire", 64'(o_ret), 64'd0);
    chk("arst_data", o_data, 64'd0);
`ifdef WB_INSTRET_EN
    chk("arst_instret", 64'(o_cnt), 64'd0);
`endif
    nxt(); rst = 1'b0; idle();
    settle();
    nxt(); ld(64'hAB, 4'b1000, 1'b0, 3'd0, 1'b1, 1'b1);
    settle();
    nxt(); idle(); rst = 1'b1;
    settle();
    nxt(); rst = 1'b0;
    ld(64'h0, 4'b1000, 1'b0, 3'd0, 1'b0, 1'b0);
    settle();
    chk("post_rst_idle", 64'(o_dstall), 64'd1);
    nxt(); idle();
    settle();

`ifdef WB_INSTRET_EN
    nxt(); rst = 1'b1;
    settle();
    nxt(); rst = 1'b0;
    repeat (15) begin
      alu(64'h1, 5'd1, 1'b1, 1'b0);
      settle();
      nxt();
    end
    idle();
    settle();
    chk("cnt_full", 64'(o_cnt), 64'd15);
    nxt(); alu(64'h1, 5'd1, 1'b1, 1'b0);
    settle();
    nxt(); idle();
    settle();
    chk("cnt_wrap", 64'(o_cnt), 64'd0);
`endif

    nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
